// File: rtl/shim_ads816x_adc_cs_sequencer.sv
// ADS816x chip-select sequencer: issues back-to-back on-the-fly SPI frames,
// shifts the command out on mosi, captures miso, and keeps n_cs high for at
// least the calculated hold time between frames.
module shim_ads816x_adc_cs_sequencer #(
  parameter int unsigned CMD_BITS = 16,
  parameter int unsigned MIN_HOLD = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [7:0]          n_cs_high_time_i,
  input  logic                timing_valid_i,
  input  logic [CMD_BITS-1:0] cmd_data_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  output logic [CMD_BITS-1:0] rdata_o,
  output logic                rdata_valid_o,
  output logic                n_cs_o,
  output logic                sclk_en_o,
  output logic                mosi_o,
  input  logic                miso_i,
  output logic                busy_o
);

  localparam int unsigned     CntW    = $clog2(CMD_BITS);
  localparam logic [CntW-1:0] LastBit = CntW'(CMD_BITS - 1);
  localparam logic [7:0]      MinHold = 8'(MIN_HOLD);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFrame = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]            hold_len_q, hold_len_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic [CMD_BITS-1:0]   shift_q, shift_d;
  // Holds the first CMD_BITS-1 samples; the last one is merged in at frame end.
  logic [CMD_BITS-2:0]   rx_q, rx_d;
  logic [CMD_BITS-1:0]   rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic                  n_cs_q, n_cs_d;
  logic                  sclk_en_q, sclk_en_d;
  logic                  mosi_q, mosi_d;
  logic                  cmd_ready_q, cmd_ready_d;

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    hold_len_d    = hold_len_q;
    hold_cnt_d    = hold_cnt_q;
    shift_d       = shift_q;
    rx_d          = rx_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    n_cs_d        = n_cs_q;
    sclk_en_d     = sclk_en_q;
    mosi_d        = mosi_q;
    cmd_ready_d   = cmd_ready_q;

    unique case (state_q)
      StIdle: begin
        n_cs_d      = 1'b1;
        sclk_en_d   = 1'b0;
        mosi_d      = 1'b0;
        cmd_ready_d = timing_valid_i;
        if (cmd_valid_i && cmd_ready_q) begin
          state_d     = StFrame;
          // First bit goes out with the first n_cs-low cycle.
          mosi_d      = cmd_data_i[CMD_BITS-1];
          shift_d     = {cmd_data_i[CMD_BITS-2:0], 1'b0};
          hold_len_d  = (n_cs_high_time_i < MinHold) ? MinHold : n_cs_high_time_i;
          cmd_ready_d = 1'b0;
          bit_cnt_d   = '0;
          n_cs_d      = 1'b0;
          sclk_en_d   = 1'b1;
        end
      end

      StFrame: begin
        cmd_ready_d = 1'b0;
        rx_d        = {rx_q[CMD_BITS-3:0], miso_i};
        if (bit_cnt_q == LastBit) begin
          state_d       = StHold;
          n_cs_d        = 1'b1;
          sclk_en_d     = 1'b0;
          mosi_d        = 1'b0;
          rdata_d       = {rx_q, miso_i};
          rdata_valid_d = 1'b1;
          hold_cnt_d    = '0;
          bit_cnt_d     = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
          mosi_d    = shift_q[CMD_BITS-1];
          shift_d   = {shift_q[CMD_BITS-2:0], 1'b0};
        end
      end

      StHold: begin
        n_cs_d      = 1'b1;
        sclk_en_d   = 1'b0;
        mosi_d      = 1'b0;
        cmd_ready_d = 1'b0;
        // hold_len_q >= 1, so the compare never underflows; 255 never wraps.
        if (hold_cnt_q == hold_len_q - 8'd1) begin
          state_d     = StIdle;
          hold_cnt_d  = '0;
          // Ready in the first idle cycle so that cycle can be the accept cycle.
          cmd_ready_d = timing_valid_i;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d     = StIdle;
        n_cs_d      = 1'b1;
        sclk_en_d   = 1'b0;
        mosi_d      = 1'b0;
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      hold_len_q    <= '0;
      hold_cnt_q    <= '0;
      shift_q       <= '0;
      rx_q          <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      n_cs_q        <= 1'b1;
      sclk_en_q     <= 1'b0;
      mosi_q        <= 1'b0;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_len_q    <= hold_len_d;
      hold_cnt_q    <= hold_cnt_d;
      shift_q       <= shift_d;
      rx_q          <= rx_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      n_cs_q        <= n_cs_d;
      sclk_en_q     <= sclk_en_d;
      mosi_q        <= mosi_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign n_cs_o        = n_cs_q;
  assign sclk_en_o     = sclk_en_q;
  assign mosi_o        = mosi_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_shim_ads816x_adc_cs_sequencer.sv
// Self-checking bench for the ADS816x chip-select sequencer.
module tb_shim_ads816x_adc_cs_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  n_cs_high_time;
  logic        timing_valid;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        n_cs;
  logic        sclk_en;
  logic        mosi;
  logic        miso;
  logic        busy;

  always #5 clk = ~clk;

  shim_ads816x_adc_cs_sequencer #(
    .CMD_BITS(16),
    .MIN_HOLD(1)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .n_cs_high_time_i(n_cs_high_time),
    .timing_valid_i  (timing_valid),
    .cmd_data_i      (cmd_data),
    .cmd_valid_i     (cmd_valid),
    .cmd_ready_o     (cmd_ready),
    .rdata_o         (rdata),
    .rdata_valid_o   (rdata_valid),
    .n_cs_o          (n_cs),
    .sclk_en_o       (sclk_en),
    .mosi_o          (mosi),
    .miso_i          (miso),
    .busy_o          (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  hold_in;
    logic [7:0]  hold_mid;   // n_cs_high_time applied from frame cycle 3 on
    logic [15:0] cmd;
    logic [15:0] miso_word;
    int          exp_hold;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int c = 0;
    while (!cmd_ready && c < 400) begin
      step();
      c++;
    end
    check("wait_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command in the current (ready) cycle and measure the frame.
  task automatic run_frame(input vec_t v, output int lo, output int sclk_n, output int rv,
                           output int hi, output logic [15:0] mosi_w, output logic [15:0] rd,
                           output int rv_pos, output bit first_low, output int sclk_bad,
                           output int busy_bad, output bit timed_out);
    bit done = 1'b0;
    lo = 0; sclk_n = 0; rv = 0; hi = 0; mosi_w = '0; rd = '0; rv_pos = 0;
    sclk_bad = 0; busy_bad = 0;
    n_cs_high_time = v.hold_in;
    cmd_data       = v.cmd;
    cmd_valid      = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_data  = 16'($urandom);
    first_low = (n_cs == 1'b0);
    for (int c = 0; c < 400; c++) begin
      if (n_cs == 1'b0) begin
        if (lo < 16) miso = v.miso_word[15-lo];
        if (lo == 3) n_cs_high_time = v.hold_mid;
        lo++;
      end else begin
        miso = 1'($urandom);
        if (lo > 0 && !cmd_ready) hi++;
      end
      if (sclk_en) begin
        sclk_n++;
        mosi_w = {mosi_w[14:0], mosi};
      end
      if (sclk_en !== ~n_cs) sclk_bad++;
      if (busy !== ((n_cs == 1'b0) || (lo > 0 && !cmd_ready))) busy_bad++;
      if (rdata_valid) begin
        rv++;
        rd = rdata;
        if (rv_pos == 0) rv_pos = hi;
      end
      if (lo > 0 && n_cs && cmd_ready) begin
        done = 1'b1;
        break;
      end
      step();
    end
    timed_out = !done;
  endtask

  // Random-phase expected timeline, built per accepted transaction.
  localparam int RN = 700;
  bit          e_ncs  [0:1023];
  bit          e_sclk [0:1023];
  bit          e_mosi [0:1023];
  bit          e_miso [0:1023];
  bit          e_busy [0:1023];
  bit          e_rv   [0:1023];
  logic [15:0] e_rdata[0:1023];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, sclk_n, rv, hi, rv_pos, sclk_bad, busy_bad, bad, starts, extra, rdy_seen;
    int start_t[3];
    int accepts, free_at, h;
    bit first_low, timed_out, prev_ncs, exp_ready;
    logic [15:0] mosi_w, rd, word;

    vecs[0] = '{8'd10,  8'd10,  16'hA5C3, 16'h1234, 10};
    vecs[1] = '{8'd3,   8'd3,   16'hFFFF, 16'h0000, 3};
    vecs[2] = '{8'd0,   8'd0,   16'h0001, 16'h8001, 1};
    vecs[3] = '{8'd255, 8'd255, 16'h8000, 16'hFFFF, 255};
    vecs[4] = '{8'd5,   8'd50,  16'h5A5A, 16'hC3A5, 5};
    vecs[5] = '{8'd1,   8'd0,   16'h1357, 16'h2468, 1};

    reset = 1'b1; timing_valid = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    n_cs_high_time = 8'd10; miso = 1'b0;
    step();
    step();
    check("reset_state", 32'({n_cs, sclk_en, mosi, cmd_ready, rdata_valid, busy, rdata}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));

    // timing_valid low: commands must be ignored.
    reset = 1'b0; cmd_valid = 1'b1; cmd_data = 16'hDEAD;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cmd_ready || !n_cs || busy) bad++;
    end
    check("no_timing_valid_ignored", 32'(bad), 32'd0);
    cmd_valid = 1'b0; timing_valid = 1'b1;
    step();
    check("ready_after_timing_valid", 32'(cmd_ready), 32'd1);

    // Table-driven single frames.
    for (int i = 0; i < 6; i++) begin
      wait_ready();
      run_frame(vecs[i], lo, sclk_n, rv, hi, mosi_w, rd, rv_pos, first_low, sclk_bad,
                busy_bad, timed_out);
      check($sformatf("v%0d_timeout", i), 32'(timed_out), 32'd0);
      check($sformatf("v%0d_first_low", i), 32'(first_low), 32'd1);
      check($sformatf("v%0d_low_cycles", i), 32'(lo), 32'd16);
      check($sformatf("v%0d_sclk_cycles", i), 32'(sclk_n), 32'd16);
      check($sformatf("v%0d_mosi", i), 32'(mosi_w), 32'(vecs[i].cmd));
      check($sformatf("v%0d_rv_count", i), 32'(rv), 32'd1);
      check($sformatf("v%0d_rdata", i), 32'(rd), 32'(vecs[i].miso_word));
      check($sformatf("v%0d_rv_pos", i), 32'(rv_pos), 32'd1);
      check($sformatf("v%0d_hold", i), 32'(hi), 32'(vecs[i].exp_hold));
      check($sformatf("v%0d_sclk_vs_ncs", i), 32'(sclk_bad), 32'd0);
      check($sformatf("v%0d_busy", i), 32'(busy_bad), 32'd0);
    end

    // Continuous cmd_valid, hold 3: frames start every 20 cycles.
    wait_ready();
    n_cs_high_time = 8'd3; cmd_valid = 1'b1; cmd_data = 16'($urandom);
    accepts = 0; starts = 0; rv = 0; prev_ncs = 1'b1; lo = 0;
    for (int c = 0; c < 90; c++) begin
      if (accepts == 3) cmd_valid = 1'b0;
      if (prev_ncs && !n_cs) begin
        if (starts < 3) start_t[starts] = c;
        starts++;
      end
      if (!n_cs) lo++;
      prev_ncs = n_cs;
      if (rdata_valid) rv++;
      if (cmd_valid && cmd_ready) accepts++;
      step();
      cmd_data = 16'($urandom);
    end
    check("cont_starts", 32'(starts), 32'd3);
    check("cont_low_total", 32'(lo), 32'd48);
    check("cont_rv_count", 32'(rv), 32'd3);
    if (starts >= 3) begin
      check("cont_spacing_1", 32'(start_t[1] - start_t[0]), 32'd20);
      check("cont_spacing_2", 32'(start_t[2] - start_t[1]), 32'd20);
    end

    // Continuous cmd_valid, hold 0 -> floor of 1: 18-cycle spacing.
    wait_ready();
    n_cs_high_time = 8'd0; cmd_valid = 1'b1;
    accepts = 0; starts = 0; prev_ncs = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (accepts == 2) cmd_valid = 1'b0;
      if (prev_ncs && !n_cs) begin
        if (starts < 3) start_t[starts] = c;
        starts++;
      end
      prev_ncs = n_cs;
      if (cmd_valid && cmd_ready) accepts++;
      step();
    end
    check("hold0_starts", 32'(starts), 32'd2);
    if (starts >= 2) check("hold0_spacing", 32'(start_t[1] - start_t[0]), 32'd18);

    // timing_valid falls mid-frame: frame completes, nothing further starts.
    wait_ready();
    n_cs_high_time = 8'd2; cmd_data = 16'hC0DE; cmd_valid = 1'b1;
    step();
    lo = 0; rv = 0; rd = '0; extra = 0; rdy_seen = 0; word = 16'hBEEF;
    for (int c = 0; c < 80; c++) begin
      if (!n_cs) begin
        if (lo < 16) begin
          miso = word[15-lo];
          if (lo == 5) timing_valid = 1'b0;
          lo++;
        end else begin
          extra++;
        end
      end
      if (rdata_valid) begin
        rv++;
        rd = rdata;
      end
      if (cmd_ready) rdy_seen++;
      step();
    end
    check("tvdrop_low_cycles", 32'(lo), 32'd16);
    check("tvdrop_rv_count", 32'(rv), 32'd1);
    check("tvdrop_rdata", 32'(rd), 32'hBEEF);
    check("tvdrop_extra_frames", 32'(extra), 32'd0);
    check("tvdrop_ready_seen", 32'(rdy_seen), 32'd0);

    // Reset at frame cycle 7.
    cmd_valid = 1'b0; timing_valid = 1'b1;
    wait_ready();
    n_cs_high_time = 8'd4; cmd_data = 16'h0F0F; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    lo = 0;
    for (int c = 0; c < 20 && lo < 7; c++) begin
      if (!n_cs) lo++;
      if (lo < 7) step();
    end
    check("rst_mid_reached_k7", 32'({n_cs, 8'(lo)}), 32'({1'b0, 8'd7}));
    reset = 1'b1;
    step();
    check("rst_mid_outputs", 32'({n_cs, sclk_en, rdata_valid, busy, cmd_ready}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    reset = 1'b0;
    step();
    check("rst_mid_ready_after_release", 32'(cmd_ready), 32'd1);
    rv = 0;
    for (int c = 0; c < 30; c++) begin
      if (rdata_valid || !n_cs) rv++;
      step();
    end
    check("rst_mid_no_rv", 32'(rv), 32'd0);

    // Randomized phase against a transaction-level timeline model.
    for (int i = 0; i < 1024; i++) begin
      e_ncs[i] = 1'b1; e_sclk[i] = 1'b0; e_mosi[i] = 1'b0; e_miso[i] = 1'b0;
      e_busy[i] = 1'b0; e_rv[i] = 1'b0; e_rdata[i] = '0;
    end
    cmd_valid = 1'b0; timing_valid = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    free_at = 1;
    for (int t = 0; t < RN; t++) begin
      exp_ready = (t >= free_at);
      check("rand_ctl", 32'({n_cs, sclk_en, mosi, cmd_ready, busy, rdata_valid}),
            32'({e_ncs[t], e_sclk[t], e_mosi[t], exp_ready, e_busy[t], e_rv[t]}));
      if (e_rv[t]) check("rand_rdata", 32'(rdata), 32'(e_rdata[t]));
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_data  = 16'($urandom);
      h = int'($urandom_range(0, 9));
      if (h == 0) n_cs_high_time = 8'd0;
      else if (h == 1) n_cs_high_time = 8'($urandom_range(20, 40));
      else n_cs_high_time = 8'($urandom_range(1, 6));
      miso = e_ncs[t] ? 1'($urandom) : e_miso[t];
      if (cmd_valid && exp_ready) begin
        h = (n_cs_high_time == 8'd0) ? 1 : int'(n_cs_high_time);
        word = 16'($urandom);
        for (int k = 0; k < 16; k++) begin
          e_ncs[t+1+k]  = 1'b0;
          e_sclk[t+1+k] = 1'b1;
          e_mosi[t+1+k] = cmd_data[15-k];
          e_miso[t+1+k] = word[15-k];
          e_busy[t+1+k] = 1'b1;
        end
        for (int j = 1; j <= h; j++) e_busy[t+16+j] = 1'b1;
        e_rv[t+17]    = 1'b1;
        e_rdata[t+17] = word;
        free_at       = t + 17 + h;
      end
      step();
    end
    cmd_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
